// File: rtl/consec_seq_checker_if.sv
// Stimulus/result bundle for consec_seq_checker: the generator drives a/b/c,
// the checker drives the match/fail pulses and status.
interface consec_seq_checker_if #(
    parameter int MAX_REP = 4,
    parameter int CW      = $clog2(MAX_REP + 1)
);
    logic          a;
    logic          b;
    logic          c;
    logic          match;
    logic          fail;
    logic [1:0]    fail_code;
    logic          busy;
    logic [CW-1:0] run_len;

    modport master (
        output a, b, c,
        input  match, fail, fail_code, busy, run_len
    );

    modport slave (
        input  a, b, c,
        output match, fail, fail_code, busy, run_len
    );
endinterface

// File: rtl/consec_seq_checker.sv
// Recognizer for a ##1 b[*MIN_REP:MAX_REP] ##1 c with one-cycle match/fail pulses.
// Optional macro CONSEC_RESTART_EN: an `a` on a terminating sample starts a new attempt.
module consec_seq_checker #(
    parameter int MIN_REP = 2,
    parameter int MAX_REP = 4,
    parameter int CW      = $clog2(MAX_REP + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    consec_seq_checker_if.slave  bus
);

`ifdef CONSEC_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    localparam logic [CW-1:0] MIN_L = CW'(MIN_REP);
    localparam logic [CW-1:0] MAX_L = CW'(MAX_REP);
    localparam logic [CW-1:0] ONE_L = CW'(1);

    localparam logic [1:0] CODE_NO_B    = 2'd1;
    localparam logic [1:0] CODE_SHORT   = 2'd2;
    localparam logic [1:0] CODE_OVERRUN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        IN_B  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] run_len_q, run_len_d;
    logic          match_q, match_d;
    logic          fail_q, fail_d;
    logic [1:0]    code_q, code_d;
    logic          busy_q, busy_d;
    logic          term;

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        match_d   = 1'b0;
        fail_d    = 1'b0;
        code_d    = 2'd0;
        term      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.a) begin
                    state_d   = GOT_A;
                    run_len_d = '0;
                end
            end
            GOT_A: begin
                if (bus.b) begin
                    state_d   = IN_B;
                    run_len_d = ONE_L;
                end else begin
                    fail_d = 1'b1;
                    code_d = CODE_NO_B;
                    term   = 1'b1;
                end
            end
            IN_B: begin
                // Priority order matters: a valid c wins regardless of b.
                if (run_len_q >= MIN_L && bus.c) begin
                    match_d = 1'b1;
                    term    = 1'b1;
                end else if (bus.b && run_len_q < MAX_L) begin
                    run_len_d = run_len_q + ONE_L;
                end else if (bus.b) begin
                    fail_d = 1'b1;
                    code_d = CODE_OVERRUN;
                    term   = 1'b1;
                end else begin
                    // b dropped: either too early or broken before c.
                    fail_d = 1'b1;
                    code_d = CODE_SHORT;
                    term   = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                run_len_d = '0;
            end
        endcase

        if (term) begin
            state_d   = (RESTART && bus.a) ? GOT_A : IDLE;
            run_len_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            run_len_q <= '0;
            match_q   <= 1'b0;
            fail_q    <= 1'b0;
            code_q    <= 2'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            match_q   <= match_d;
            fail_q    <= fail_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.match     = match_q;
    assign bus.fail      = fail_q;
    assign bus.fail_code = code_q;
    assign bus.busy      = busy_q;
    assign bus.run_len   = run_len_q;

endmodule

// File: tb/tb_consec_seq_checker.sv
// Bench for consec_seq_checker: directed scenarios plus random a/b/c traffic
// checked cycle by cycle against a sample-counting reference model.
module tb_consec_seq_checker;
    localparam int MIN = 2;
    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);

`ifdef CONSEC_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    consec_seq_checker_if #(.MAX_REP(MAX)) bus ();

    consec_seq_checker #(.MIN_REP(MIN), .MAX_REP(MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an attempt is just "k samples seen since a"; every
    // surviving sample was a b, so k-1 is the b-run before the current one.
    bit         m_act;
    int         m_k;
    int         m_run;
    logic       m_match, m_fail;
    logic [1:0] m_code;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_k = 0; m_run = 0;
        m_match = 0; m_fail = 0; m_code = 0;
    endtask

    task automatic model(input logic ia, input logic ib, input logic ic);
        bit term;
        int r;
        m_match = 0; m_fail = 0; m_code = 0; term = 0;
        if (!m_act) begin
            if (ia) begin m_act = 1; m_k = 0; m_run = 0; end
        end else begin
            m_k++;
            if (m_k == 1) begin
                if (ib) m_run = 1;
                else begin m_fail = 1; m_code = 1; term = 1; end
            end else begin
                r = m_k - 1;
                if (r >= MIN && ic) begin m_match = 1; term = 1; end
                else if (ib && r < MAX) m_run = r + 1;
                else if (ib) begin m_fail = 1; m_code = 3; term = 1; end
                else begin m_fail = 1; m_code = 2; term = 1; end
            end
        end
        if (term) begin
            m_act = RESTART && ia;
            m_k   = 0;
            m_run = 0;
        end
    endtask

    task automatic step(input string tag, input logic ia, input logic ib, input logic ic);
        bus.a = ia; bus.b = ib; bus.c = ic;
        @(posedge clock);
        #1;
        model(ia, ib, ic);
        chk({tag, ".match"},   32'(bus.match),     32'(m_match));
        chk({tag, ".fail"},    32'(bus.fail),      32'(m_fail));
        chk({tag, ".code"},    32'(bus.fail_code), 32'(m_code));
        chk({tag, ".busy"},    32'(bus.busy),      32'(m_act));
        chk({tag, ".run_len"}, 32'(bus.run_len),   32'(m_run));
        chk({tag, ".excl"},    32'(bus.match & bus.fail), 32'd0);
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, ".rst_match"}, 32'(bus.match),     32'd0);
        chk({tag, ".rst_fail"},  32'(bus.fail),      32'd0);
        chk({tag, ".rst_code"},  32'(bus.fail_code), 32'd0);
        chk({tag, ".rst_busy"},  32'(bus.busy),      32'd0);
        chk({tag, ".rst_len"},   32'(bus.run_len),   32'd0);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.a = 0; bus.b = 0; bus.c = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("init.match", 32'(bus.match),     32'd0);
        chk("init.fail",  32'(bus.fail),      32'd0);
        chk("init.code",  32'(bus.fail_code), 32'd0);
        chk("init.busy",  32'(bus.busy),      32'd0);
        chk("init.len",   32'(bus.run_len),   32'd0);
        reset = 1'b0;
        step("idle", 0, 0, 0);

        // Pass: a@0, b@1-3, c@4
        step("pass", 1, 0, 0);
        chk("pass.busy_rise", 32'(bus.busy), 32'd1);
        step("pass", 0, 1, 0);
        step("pass", 0, 1, 0);
        step("pass", 0, 1, 0);
        chk("pass.len3", 32'(bus.run_len), 32'd3);
        step("pass", 0, 0, 1);
        chk("pass.hit", 32'(bus.match), 32'd1);
        chk("pass.busy_fall", 32'(bus.busy), 32'd0);
        step("pass", 0, 0, 0);
        chk("pass.one_cycle", 32'(bus.match), 32'd0);

        // No b
        step("nob", 1, 0, 0);
        step("nob", 0, 0, 0);
        chk("nob.code", 32'(bus.fail_code), 32'd1);
        step("nob", 0, 0, 0);

        // Short: early c
        step("short", 1, 0, 0);
        step("short", 0, 1, 0);
        step("short", 0, 0, 1);
        chk("short.code", 32'(bus.fail_code), 32'd2);
        step("short", 0, 0, 0);

        // Overrun
        step("ovr", 1, 0, 0);
        for (int i = 0; i < 4; i++) step("ovr", 0, 1, 0);
        chk("ovr.sat", 32'(bus.run_len), 32'd4);
        step("ovr", 0, 1, 0);
        chk("ovr.code", 32'(bus.fail_code), 32'd3);
        chk("ovr.len0", 32'(bus.run_len), 32'd0);
        step("ovr", 0, 0, 0);

        // Restart overlap
        step("rst", 1, 0, 0);
        step("rst", 0, 1, 0);
        step("rst", 0, 1, 0);
        step("rst", 1, 0, 1);
        chk("rst.first", 32'(bus.match), 32'd1);
        step("rst", 0, 1, 0);
        step("rst", 0, 1, 0);
        step("rst", 0, 0, 1);
        chk("rst.second", 32'(bus.match), RESTART ? 32'd1 : 32'd0);
        step("rst", 0, 0, 0);

        // Async reset mid IN_B with run_len=2
        step("arst", 1, 0, 0);
        step("arst", 0, 1, 0);
        step("arst", 0, 1, 0);
        chk("arst.len2", 32'(bus.run_len), 32'd2);
        async_reset("arst");
        step("arst", 1, 0, 0);
        step("arst", 0, 1, 0);
        step("arst", 0, 1, 0);
        step("arst", 0, 0, 1);
        chk("arst.pass", 32'(bus.match), 32'd1);

        // Random traffic, biased toward long b runs
        for (int i = 0; i < 3000; i++) begin
            step("rnd",
                 logic'($urandom_range(3) == 0),
                 logic'($urandom_range(3) != 0),
                 logic'($urandom_range(2) == 0));
            if ($urandom_range(150) == 0) async_reset("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
